// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet-stats datapath: action codes, the action
// input FSM states and a small priority helper.
package tamagotchi_pkg;

  localparam int unsigned ACT_W = 3;
  localparam int unsigned N_ACT = 8;

  localparam logic [ACT_W-1:0] ACT_FEED   = 3'd0;
  localparam logic [ACT_W-1:0] ACT_PLAY   = 3'd1;
  localparam logic [ACT_W-1:0] ACT_HEAL   = 3'd2;
  localparam logic [ACT_W-1:0] ACT_CLEAN  = 3'd3;
  localparam logic [ACT_W-1:0] ACT_SLEEP  = 3'd4;
  localparam logic [ACT_W-1:0] ACT_SOCIAL = 3'd5;
  localparam logic [ACT_W-1:0] ACT_RSVD6  = 3'd6;
  localparam logic [ACT_W-1:0] ACT_RSVD7  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    COOLDOWN
  } state_t;

  // Index of the lowest set request bit (bit 0 has the highest priority).
  function automatic logic [ACT_W-1:0] lowest_set(input logic [N_ACT-1:0] req);
    logic [ACT_W-1:0] idx;
    idx = '0;
    for (int unsigned i = N_ACT; i > 0; i--) begin
      if (req[ACT_W'(i - 1)]) idx = ACT_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button line: 2-flop synchroniser, 3-sample debounce history taken on
// the shared sample tick, debounced level and a one-cycle rising-edge pulse.
module button_debounce (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_rise
);

  logic       r_sync1;
  logic       r_sync2;
  logic [2:0] r_hist;
  logic       r_level;
  logic       r_level_d;
  logic [2:0] w_hist_next;

  assign w_hist_next = {r_hist[1:0], r_sync2};

  // Synchronise, sample on tick and update the debounced level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_hist    <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (i_tick) begin
        r_hist <= w_hist_next;
        if (w_hist_next == 3'b111) r_level <= 1'b1;
        else if (w_hist_next == 3'b000) r_level <= 1'b0;
      end
    end
  end

  assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/action_input.sv
// Turns raw buttons into one-at-a-time care actions: debounce, sticky
// pending requests, fixed-priority arbitration, valid/ready offer, cooldown.
module action_input
  import tamagotchi_pkg::*;
#(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd250_000,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_ACT-1:0] buttons,
  input  logic             action_ready,
  output logic             action_valid,
  output logic [ACT_W-1:0] action_code,
  output logic [N_ACT-1:0] pending,
  output logic             busy,
  output logic             lost
);

  logic [23:0]      r_tick_cnt;
  logic             w_tick;
  logic [N_ACT-1:0] w_rise;
  logic [N_ACT-1:0] r_pending;
  logic [N_ACT-1:0] w_clear;
  logic [N_ACT-1:0] w_pending_next;
  logic             w_lost_hit;
  logic             r_lost;
  logic             w_handshake;
  state_t           r_state;
  state_t           w_state_next;
  logic [ACT_W-1:0] r_code;
  logic [ACT_W-1:0] w_code_next;
  logic [23:0]      r_cool;
  logic [23:0]      w_cool_next;

  assign w_tick = (r_tick_cnt == DEBOUNCE_CYCLES - 24'd1);

  // Shared debounce sample tick counter, wrapping at DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_tick_cnt <= '0;
    else               r_tick_cnt <= r_tick_cnt + 24'd1;
  end

  for (genvar g = 0; g < N_ACT; g++) begin : g_btn
    button_debounce u_debounce (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_tick (w_tick),
      .i_btn  (buttons[g]),
      .o_rise (w_rise[g])
    );
  end

  // Handshake is built from registered state only, so ready never reaches valid/code.
  assign w_handshake = (r_state == OFFER) && action_ready;

  // One-hot clear of the action being accepted this cycle.
  always_comb begin
    w_clear = '0;
    if (w_handshake) w_clear[r_code] = 1'b1;
  end

  // A new edge re-arms its bit even if the same bit is being cleared.
  assign w_pending_next = (r_pending & ~w_clear) | w_rise;
  assign w_lost_hit     = |(w_rise & r_pending & ~w_clear);

  // Pending request flags and sticky lost flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_lost    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (w_lost_hit) r_lost <= 1'b1;
    end
  end

  // FSM state, offered code and cooldown counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_cool  <= '0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_cool  <= w_cool_next;
    end
  end

  // Next-state, code latch, cooldown load/decrement and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_cool_next  = r_cool;
    action_valid = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_state_next = OFFER;
          w_code_next  = lowest_set(r_pending);
        end
      end
      OFFER: begin
        action_valid = 1'b1;
        if (w_handshake) begin
          w_state_next = COOLDOWN;
          w_cool_next  = COOLDOWN_CYCLES - 24'd1;
        end
      end
      COOLDOWN: begin
        busy = 1'b1;
        if (r_cool == '0) w_state_next = IDLE;
        else              w_cool_next  = r_cool - 24'd1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign action_code = r_code;
  assign pending     = r_pending;
  assign lost        = r_lost;

endmodule

// File: tb/tb_action_input.sv
// Self-checking bench for action_input: directed table and sequences plus
// randomized buttons/ready checked against a cycle-level behavioural model.
module tb_action_input;

  localparam logic [23:0] DB = 24'd4;
  localparam logic [23:0] CD = 24'd8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] buttons;
  logic       ready;
  logic       action_valid;
  logic [2:0] action_code;
  logic [7:0] pending;
  logic       busy;
  logic       lost;

  logic       rst1;
  logic [7:0] buttons1;
  logic       ready1;
  logic       valid1;
  logic [2:0] code1;
  logic [7:0] pending1;
  logic       busy1;
  logic       lost1;

  always #5 clk = ~clk;

  action_input #(.DEBOUNCE_CYCLES(DB), .COOLDOWN_CYCLES(CD)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .action_ready(ready),
    .action_valid(action_valid), .action_code(action_code),
    .pending(pending), .busy(busy), .lost(lost)
  );

  action_input #(.DEBOUNCE_CYCLES(DB), .COOLDOWN_CYCLES(24'd1)) dut1 (
    .clk(clk), .rst(rst1), .buttons(buttons1), .action_ready(ready1),
    .action_valid(valid1), .action_code(code1),
    .pending(pending1), .busy(busy1), .lost(lost1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural reference model (main DUT) ----------------
  // Debounce is modelled as "three equal samples in a row", tick as every
  // DB-th cycle since reset, cooldown as a count of remaining busy cycles.
  int         m_edges;
  logic [7:0] m_s1, m_s2, m_deb, m_deb_d, m_pend;
  bit         m_lost;
  bit         m_last[8];
  int         m_run[8];
  int         m_mode;   // 0 idle, 1 offering, 2 cooling down
  int         m_code;
  int         m_left;

  always @(posedge clk) begin : model
    logic [7:0] rise;
    logic [7:0] pend_old;
    bit         hs;
    bit         tick;
    bit         smp;
    bit         found;
    if (rst) begin
      m_edges = 0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_d = '0;
      m_pend = '0; m_lost = 0; m_mode = 0; m_code = 0; m_left = 0;
      for (int i = 0; i < 8; i++) begin
        m_last[i] = 0;
        m_run[i]  = 3;
      end
    end else begin
      tick     = (m_edges % int'(DB)) == int'(DB) - 1;
      rise     = m_deb & ~m_deb_d;
      hs       = (m_mode == 1) && ready;
      pend_old = m_pend;
      for (int i = 0; i < 8; i++) begin
        if (rise[i] && pend_old[i] && !(hs && m_code == i)) m_lost = 1;
        if (rise[i]) m_pend[i] = 1'b1;
        else if (hs && m_code == i) m_pend[i] = 1'b0;
      end
      case (m_mode)
        0: if (pend_old != 0) begin
             m_mode = 1;
             found  = 0;
             for (int i = 0; i < 8; i++)
               if (pend_old[i] && !found) begin
                 m_code = i;
                 found  = 1;
               end
           end
        1: if (hs) begin
             m_mode = 2;
             m_left = int'(CD);
           end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
      m_deb_d = m_deb;
      if (tick) begin
        for (int i = 0; i < 8; i++) begin
          smp = m_s2[i];
          if (smp == m_last[i]) m_run[i] = (m_run[i] >= 3) ? 3 : m_run[i] + 1;
          else begin
            m_last[i] = smp;
            m_run[i]  = 1;
          end
          if (m_run[i] >= 3) m_deb[i] = smp;
        end
      end
      m_s2 = m_s1;
      m_s1 = buttons;
      m_edges++;
    end
  end

  // ---------------- monitor ----------------
  int hs_codes[$];
  int busy_cnt  = 0;
  int valid_cnt = 0;
  bit model_en  = 0;

  always @(negedge clk) begin
    if (action_valid && ready) hs_codes.push_back(int'(action_code));
    if (busy) busy_cnt++;
    if (action_valid) valid_cnt++;
    if (model_en) begin
      chk("rnd_valid",   int'(action_valid), int'(m_mode == 1));
      chk("rnd_busy",    int'(busy),         int'(m_mode == 2));
      chk("rnd_pending", int'(pending),      int'(m_pend));
      chk("rnd_lost",    int'(lost),         int'(m_lost));
      if (m_mode == 1) chk("rnd_code", int'(action_code), m_code);
    end
  end

  task automatic do_reset();
    rst = 1'b1; buttons = '0; ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    hs_codes.delete();
    busy_cnt  = 0;
    valid_cnt = 0;
  endtask

  typedef struct {
    logic [7:0] btn;
    int         exp_n;
    int         exp_first;
    int         exp_busy;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   waited;
    bit   stable;
    int   hs1_codes[$];
    int   hs1_cyc[$];
    int   busy_between;
    int   idx;

    for (int i = 0; i < 8; i++) vecs[i] = '{8'(1 << i), 1, i, 8};
    vecs[8] = '{8'h0A, 2, 1, 16};
    vecs[9] = '{8'hC0, 2, 6, 16};

    rst1 = 1'b1; buttons1 = '0; ready1 = 1'b0;

    // 1. Reset held with all buttons high, then debounce latency.
    rst = 1'b1; buttons = 8'hFF; ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      @(negedge clk);
      chk("rst_valid", int'(action_valid), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_lost", int'(lost), 0);
    end
    chk("rst_code", int'(action_code), 0);
    cyc(1);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      @(negedge clk);
      chk("rst_no_early_rise", int'(pending), 0);
    end
    cyc(1);
    @(negedge clk);
    chk("rst_first_pending", int'(pending), 8'hFF);
    cyc(1);
    @(negedge clk);
    chk("rst_first_valid", int'(action_valid), 1);
    chk("rst_first_code", int'(action_code), 0);

    // 2. Table of clean presses.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      buttons = vecs[v].btn;
      ready   = 1'b1;
      cyc(20);
      buttons = '0;
      cyc(60);
      @(negedge clk);
      chk("tbl_hs_count", hs_codes.size(), vecs[v].exp_n);
      chk("tbl_first_code", (hs_codes.size() > 0) ? hs_codes[0] : -1, vecs[v].exp_first);
      chk("tbl_busy_cycles", busy_cnt, vecs[v].exp_busy);
      chk("tbl_pending_end", int'(pending), 0);
    end

    // 3. Bounce: half-period of 3 so no phase of the 4-cycle tick sees three equal samples.
    do_reset();
    ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      buttons[0] = ((k / 3) % 2) == 0;
      cyc(1);
    end
    buttons = '0;
    cyc(30);
    @(negedge clk);
    chk("bounce_no_valid", valid_cnt, 0);
    chk("bounce_no_pending", int'(pending), 0);
    for (int k = 0; k < 30; k++) begin
      buttons[0] = ((k / 3) % 2) == 0;
      cyc(1);
    end
    buttons[0] = 1'b1;
    cyc(16);
    buttons = '0;
    cyc(50);
    @(negedge clk);
    chk("bounce_then_hold_count", hs_codes.size(), 1);
    chk("bounce_then_hold_code", (hs_codes.size() > 0) ? hs_codes[0] : -1, 0);

    // 4. Priority and hold under stall.
    do_reset();
    buttons = 8'h22;
    waited  = 0;
    do begin
      cyc(1);
      @(negedge clk);
      waited++;
    end while (!action_valid && waited < 40);
    chk("prio_valid", int'(action_valid), 1);
    chk("prio_code", int'(action_code), 1);
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      @(negedge clk);
      if (!action_valid || action_code != 3'd1) stable = 0;
    end
    chk("prio_stable", int'(stable), 1);
    buttons[0] = 1'b1;
    cyc(24);
    @(negedge clk);
    chk("prio_hold_code", int'(action_code), 1);
    chk("prio_pending", int'(pending), 8'h23);
    cyc(1);
    ready  = 1'b1;
    waited = 0;
    while (hs_codes.size() < 3 && waited < 100) begin
      cyc(1);
      waited++;
    end
    cyc(12);
    @(negedge clk);
    chk("prio_hs_count", hs_codes.size(), 3);
    chk("prio_order0", (hs_codes.size() > 0) ? hs_codes[0] : -1, 1);
    chk("prio_order1", (hs_codes.size() > 1) ? hs_codes[1] : -1, 0);
    chk("prio_order2", (hs_codes.size() > 2) ? hs_codes[2] : -1, 5);
    chk("prio_busy_total", busy_cnt, 24);

    // 5. Lost flag on a re-press while still pending.
    do_reset();
    cyc(1);
    @(negedge clk);
    chk("lost_clear_start", int'(lost), 0);
    cyc(1);
    buttons = 8'h10; cyc(16);
    buttons = 8'h00; cyc(16);
    buttons = 8'h10; cyc(16);
    buttons = 8'h00; cyc(16);
    @(negedge clk);
    chk("lost_set", int'(lost), 1);
    chk("lost_pending4", int'(pending[4]), 1);
    chk("lost_offer_code", int'(action_code), 4);
    cyc(1);
    ready = 1'b1;
    cyc(40);
    @(negedge clk);
    chk("lost_single_delivery", hs_codes.size(), 1);
    chk("lost_delivery_code", (hs_codes.size() > 0) ? hs_codes[0] : -1, 4);
    chk("lost_sticky", int'(lost), 1);

    // 6a. Reset during COOLDOWN with another request pending.
    do_reset();
    ready   = 1'b1;
    buttons = 8'h06;
    waited  = 0;
    do begin
      cyc(1);
      @(negedge clk);
      waited++;
    end while (!busy && waited < 60);
    chk("rstcd_reached_busy", int'(busy), 1);
    chk("rstcd_pending_before", int'(pending), 8'h04);
    rst = 1'b1; buttons = '0;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstcd_valid", int'(action_valid), 0);
    chk("rstcd_busy", int'(busy), 0);
    chk("rstcd_pending", int'(pending), 0);

    // 6b. Reset during OFFER.
    ready   = 1'b0;
    buttons = 8'h08;
    waited  = 0;
    do begin
      cyc(1);
      @(negedge clk);
      waited++;
    end while (!action_valid && waited < 60);
    chk("rstof_reached_offer", int'(action_valid), 1);
    rst = 1'b1; buttons = '0;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstof_valid", int'(action_valid), 0);
    chk("rstof_busy", int'(busy), 0);
    chk("rstof_pending", int'(pending), 0);

    // 6c. One-cycle cooldown: back-to-back offers.
    cyc(1);
    rst1 = 1'b0; buttons1 = 8'h44; ready1 = 1'b1;
    busy_between = 0;
    for (int k = 0; k < 80 && hs1_codes.size() < 2; k++) begin
      cyc(1);
      @(negedge clk);
      if (valid1 && ready1) begin
        hs1_codes.push_back(int'(code1));
        hs1_cyc.push_back(k);
      end
      if (busy1 && hs1_codes.size() == 1) busy_between++;
    end
    chk("cd1_hs_count", hs1_codes.size(), 2);
    chk("cd1_code0", (hs1_codes.size() > 0) ? hs1_codes[0] : -1, 2);
    chk("cd1_code1", (hs1_codes.size() > 1) ? hs1_codes[1] : -1, 6);
    chk("cd1_busy_between", busy_between, 1);
    chk("cd1_hs_spacing", (hs1_cyc.size() > 1) ? hs1_cyc[1] - hs1_cyc[0] : -1, 3);
    cyc(1);
    buttons1 = '0;

    // Randomized buttons, ready and occasional reset against the model.
    do_reset();
    model_en = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        idx = int'($urandom_range(0, 7));
        buttons[idx] = ~buttons[idx];
      end
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    model_en = 0;
    cyc(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
